// File: rtl/ps2_rx_buffered_if.sv
// Host-side read port of the buffered PS/2 receiver.
// master = host, slave = receiver.
interface ps2_rx_buffered_if #(
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          KB_read_en;
   logic          KB_clear;
   logic          KB_status;
   logic [7:0]    KB_data;
   logic          buf_full;
   logic [CW-1:0] KB_count;
   logic          frame_err;
   logic          overflow;

   modport master (
      output KB_read_en, KB_clear,
      input  KB_status, KB_data, buf_full,
      input  KB_count, frame_err, overflow
   );

   modport slave (
      input  KB_read_en, KB_clear,
      output KB_status, KB_data, buf_full,
      output KB_count, frame_err, overflow
   );
endinterface

// File: rtl/ps2_rx_buffered.sv
// PS/2 frame receiver with parity/stop/timeout checking
// feeding a first-word fall-through FIFO.
module ps2_rx_buffered #(
   parameter int DEPTH        = 16,
   parameter int SYNC_STAGES  = 2,
   parameter int TIMEOUT_CYC  = 50000,
   parameter bit BREAK_FILTER = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PS2_clk,
   input  logic             PS2_data,
   ps2_rx_buffered_if.slave kb
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] c_sync, d_sync;
   logic          c_prev;
   logic          ps2c, ps2d, fall;
   state_t        state_q, state_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic          par_q, par_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          byte_ok, ferr_set;
   logic          vld_q;
   logic [7:0]    vbyte_q;
   logic          skip_q, is_brk;
   logic          push_req, push, pop, full, empty;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   logic          ferr_q, ovf_q;

   // Idle-high lines: synchronizers reset to 1 so no false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_sync <= '1;
         d_sync <= '1;
         c_prev <= 1'b1;
      end else begin
         c_sync <= {c_sync[SYNC_STAGES-2:0], PS2_clk};
         d_sync <= {d_sync[SYNC_STAGES-2:0], PS2_data};
         c_prev <= c_sync[SYNC_STAGES-1];
      end
   end

   assign ps2c = c_sync[SYNC_STAGES-1];
   assign ps2d = d_sync[SYNC_STAGES-1];
   assign fall = c_prev & ~ps2c;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      sh_d     = sh_q;
      par_d    = par_q;
      tcnt_d   = '0;
      byte_ok  = 1'b0;
      ferr_set = 1'b0;
      if (state_q != IDLE)
         tcnt_d = tcnt_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            if (fall && !ps2d) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (fall) begin
               sh_d  = {ps2d, sh_q[7:1]};
               idx_d = idx_q + 1'b1;
               if (idx_q == 3'd7)
                  state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = ps2d;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_d = IDLE;
               if (ps2d && (^{sh_q, par_q}))
                  byte_ok = 1'b1;
               else
                  ferr_set = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (fall)
         tcnt_d = '0;
      // Device went silent mid-frame: drop the partial byte.
      if (state_q != IDLE && !fall &&
          tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
         state_d  = IDLE;
         ferr_set = 1'b1;
         tcnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         tcnt_q  <= '0;
         vld_q   <= 1'b0;
         vbyte_q <= '0;
      end else if (kb.KB_clear) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tcnt_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         tcnt_q  <= tcnt_d;
         vld_q   <= byte_ok;
         vbyte_q <= sh_q;
      end
   end

   assign is_brk   = (vbyte_q == 8'hF0);
   assign push_req = vld_q &
                     ~(BREAK_FILTER & (skip_q | is_brk));
   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign pop      = kb.KB_read_en & ~empty;
   assign push     = push_req & (~full | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         skip_q  <= 1'b0;
      end else if (kb.KB_clear) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ferr_q  <= 1'b0;
         ovf_q   <= 1'b0;
         skip_q  <= 1'b0;
      end else begin
         if (push)
            wptr_q <= wptr_q + 1'b1;
         if (pop)
            rptr_q <= rptr_q + 1'b1;
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (pop && !push)
            count_q <= count_q - 1'b1;
         if (ferr_set)
            ferr_q <= 1'b1;
         if (push_req && full && !pop)
            ovf_q <= 1'b1;
         // Break prefix arms, the byte after it disarms.
         if (BREAK_FILTER && vld_q)
            skip_q <= ~skip_q & is_brk;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !kb.KB_clear)
         mem[wptr_q] <= vbyte_q;
   end

   assign kb.KB_status = ~empty;
   assign kb.KB_data   = empty ? 8'h00 : mem[rptr_q];
   assign kb.buf_full  = full;
   assign kb.KB_count  = count_q;
   assign kb.frame_err = ferr_q;
   assign kb.overflow  = ovf_q;
endmodule

// File: tb/tb_ps2_rx_buffered.sv
// Directed + randomized bench for ps2_rx_buffered against a
// queue-based model of the receiver and its FIFO.
module tb_ps2_rx_buffered;
   localparam int H  = 8;
   localparam int TO = 200;
   localparam int D0 = 16;
   localparam int D1 = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic c0 = 1'b1, d0 = 1'b1, c1 = 1'b1, d1 = 1'b1;

   int checks   = 0;
   int failures = 0;
   int lat, scratch;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit ferr_m[2];
   bit ovf_m[2];
   bit skip_m;

   always #5 clk = ~clk;

   ps2_rx_buffered_if #(.DEPTH(D0)) kb0();
   ps2_rx_buffered_if #(.DEPTH(D1)) kb1();

   ps2_rx_buffered #(
      .DEPTH(D0), .SYNC_STAGES(2),
      .TIMEOUT_CYC(TO), .BREAK_FILTER(1'b0)
   ) u0 (
      .clk(clk), .rst_n(rst_n),
      .PS2_clk(c0), .PS2_data(d0), .kb(kb0)
   );

   ps2_rx_buffered #(
      .DEPTH(D1), .SYNC_STAGES(2),
      .TIMEOUT_CYC(TO), .BREAK_FILTER(1'b1)
   ) u1 (
      .clk(clk), .rst_n(rst_n),
      .PS2_clk(c1), .PS2_data(d1), .kb(kb1)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   function automatic int get_cnt(input int ch);
      return (ch == 0) ? int'(kb0.KB_count)
                       : int'(kb1.KB_count);
   endfunction

   task automatic drive(input int ch, input logic c,
                        input logic d);
      if (ch == 0) begin c0 = c; d0 = d; end
      else begin c1 = c; d1 = d; end
   endtask

   task automatic set_re(input int ch, input logic v);
      if (ch == 0) kb0.KB_read_en = v;
      else kb1.KB_read_en = v;
   endtask

   // Model: what a completed frame does to the buffer.
   task automatic model_frame(input int ch,
                              input logic [7:0] b,
                              input bit ok);
      if (!ok) ferr_m[ch] = 1'b1;
      else if (ch == 1 && skip_m) skip_m = 1'b0;
      else if (ch == 1 && b == 8'hF0) skip_m = 1'b1;
      else if (ch == 0) begin
         if (q0.size() == D0) ovf_m[0] = 1'b1;
         else q0.push_back(b);
      end else begin
         if (q1.size() == D1) ovf_m[1] = 1'b1;
         else q1.push_back(b);
      end
   endtask

   task automatic model_pop(input int ch);
      if (ch == 0 && q0.size() > 0) void'(q0.pop_front());
      if (ch == 1 && q1.size() > 0) void'(q1.pop_front());
   endtask

   task automatic model_clear(input int ch);
      if (ch == 0) q0.delete();
      else begin q1.delete(); skip_m = 1'b0; end
      ferr_m[ch] = 1'b0;
      ovf_m[ch]  = 1'b0;
   endtask

   // Drives nbits of a frame; optionally pops on edge pop_at
   // of the stop-bit low phase; reports first count change.
   task automatic send_bits(input int ch,
                            input logic [7:0] b,
                            input int nbits,
                            input bit pflip,
                            input bit stop,
                            input int pop_at,
                            output int l);
      logic [10:0] f;
      int c_0;
      f   = {stop, (~^b) ^ pflip, b, 1'b0};
      l   = -1;
      c_0 = get_cnt(ch);
      for (int i = 0; i < nbits; i++) begin
         drive(ch, 1'b1, f[i]);
         repeat (H) @(posedge clk);
         #1;
         drive(ch, 1'b0, f[i]);
         for (int k = 1; k <= H; k++) begin
            if (pop_at == k && i == 10) set_re(ch, 1'b1);
            @(posedge clk);
            #1;
            set_re(ch, 1'b0);
            if (l < 0 && get_cnt(ch) != c_0) l = k;
         end
         drive(ch, 1'b1, f[i]);
      end
      repeat (2 * H) @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input logic [7:0] b,
                       input bit pflip, input bit stop);
      int l;
      send_bits(ch, b, 11, pflip, stop, 0, l);
      model_frame(ch, b, !pflip && stop);
   endtask

   task automatic pop_once(input int ch);
      set_re(ch, 1'b1);
      @(posedge clk);
      #1;
      set_re(ch, 1'b0);
      model_pop(ch);
   endtask

   task automatic clear(input int ch);
      if (ch == 0) kb0.KB_clear = 1'b1;
      else kb1.KB_clear = 1'b1;
      @(posedge clk);
      #1;
      kb0.KB_clear = 1'b0;
      kb1.KB_clear = 1'b0;
      model_clear(ch);
   endtask

   task automatic check_all(input int ch, input string tag);
      logic [31:0] n, e_n, e_d;
      if (ch == 0) begin
         n   = q0.size();
         e_d = (q0.size() > 0) ? 32'(q0[0]) : 32'h0;
         chk({tag, ".count"}, 32'(kb0.KB_count), n);
         chk({tag, ".status"}, 32'(kb0.KB_status), 32'(n != 0));
         chk({tag, ".data"}, 32'(kb0.KB_data), e_d);
         chk({tag, ".full"}, 32'(kb0.buf_full), 32'(n == D0));
         chk({tag, ".ferr"}, 32'(kb0.frame_err), 32'(ferr_m[0]));
         chk({tag, ".ovf"}, 32'(kb0.overflow), 32'(ovf_m[0]));
      end else begin
         n   = q1.size();
         e_d = (q1.size() > 0) ? 32'(q1[0]) : 32'h0;
         chk({tag, ".count"}, 32'(kb1.KB_count), n);
         chk({tag, ".status"}, 32'(kb1.KB_status), 32'(n != 0));
         chk({tag, ".data"}, 32'(kb1.KB_data), e_d);
         chk({tag, ".full"}, 32'(kb1.buf_full), 32'(n == D1));
         chk({tag, ".ferr"}, 32'(kb1.frame_err), 32'(ferr_m[1]));
         chk({tag, ".ovf"}, 32'(kb1.overflow), 32'(ovf_m[1]));
      end
      e_n = 0;
   endtask

   initial begin
      logic [7:0] b;
      int r;
      kb0.KB_read_en = 1'b0;
      kb0.KB_clear   = 1'b0;
      kb1.KB_read_en = 1'b0;
      kb1.KB_clear   = 1'b0;
      model_clear(0);
      model_clear(1);
      repeat (4) @(posedge clk);
      #1;
      check_all(0, "rst0");
      check_all(1, "rst1");
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      send_bits(0, 8'h33, 11, 1'b0, 1'b1, 0, lat);
      model_frame(0, 8'h33, 1'b1);
      check_all(0, "f33");
      chk("push_latency_ok", 32'(lat >= 3 && lat <= 7), 32'd1);
      if (lat < 1 || lat > H) lat = 4;
      pop_once(0);
      check_all(0, "pop33");

      send(0, 8'h33, 1'b1, 1'b1);
      check_all(0, "badpar");
      send(0, 8'h1C, 1'b0, 1'b1);
      check_all(0, "f1c_sticky");
      send(0, 8'($urandom), 1'b0, 1'b0);
      check_all(0, "badstop");
      clear(0);
      check_all(0, "clr");

      for (int i = 0; i < 24; i++) begin
         b = 8'($urandom);
         r = $urandom_range(0, 9);
         send(0, b, r == 0, r != 1);
         r = $urandom_range(0, 2);
         for (int k = 0; k < r; k++) pop_once(0);
         check_all(0, "rnd");
      end

      clear(0);
      for (int i = 0; i < 17; i++) send(0, 8'(i), 1'b0, 1'b1);
      check_all(0, "full17");
      for (int i = 0; i < 16; i++) begin
         chk("drain_order", 32'(kb0.KB_data), 32'(i));
         pop_once(0);
         check_all(0, "drain");
      end

      clear(0);
      for (int i = 0; i < 16; i++)
         send(0, 8'($urandom), 1'b0, 1'b1);
      b = 8'($urandom);
      send_bits(0, b, 11, 1'b0, 1'b1, lat, scratch);
      model_pop(0);
      model_frame(0, b, 1'b1);
      check_all(0, "pushpop_full");
      for (int i = 0; i < 15; i++) pop_once(0);
      chk("pushpop_last", 32'(kb0.KB_data), 32'(b));
      check_all(0, "pushpop_tail");

      clear(0);
      send_bits(0, 8'h5A, 6, 1'b0, 1'b1, 0, scratch);
      repeat (TO + 10) @(posedge clk);
      #1;
      ferr_m[0] = 1'b1;
      check_all(0, "timeout");
      send(0, 8'h2A, 1'b0, 1'b1);
      check_all(0, "after_to");

      send(1, 8'hF0, 1'b0, 1'b1);
      send(1, 8'h1C, 1'b0, 1'b1);
      send(1, 8'h1C, 1'b0, 1'b1);
      check_all(1, "brk");
      clear(1);
      for (int i = 0; i < 12; i++) begin
         b = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom);
         r = $urandom_range(0, 11);
         send(1, b, r == 0, 1'b1);
         if ($urandom_range(0, 2) == 0) pop_once(1);
         check_all(1, "brk_rnd");
      end

      send_bits(1, 8'h5A, 4, 1'b0, 1'b1, 0, scratch);
      d1 = 1'b1;
      rst_n = 1'b0;
      #1;
      model_clear(0);
      model_clear(1);
      check_all(0, "arst0");
      check_all(1, "arst1");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      send(1, 8'h55, 1'b0, 1'b1);
      check_all(1, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
